// File: rtl/dm_responder.sv
// Data-memory responder: byte-masked writes, combinational reads, sticky error flags and
// a registered write-trace stream that is only generated when DM_TRACE_EN is defined.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [15:0] wr_count,
    output logic        err_oor,
    output logic        err_byteen,
    output logic [31:0] err_addr
);

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             wr_req;
    logic             wr_commit;
    logic             byteen_legal;
    logic [31:0]      rd_word;
    logic [31:0]      merged_word;

    logic [15:0] wr_count_q,   wr_count_d;
    logic        err_oor_q,    err_oor_d;
    logic        err_byteen_q, err_byteen_d;
    logic [31:0] err_addr_q,   err_addr_d;

    assign idx       = m_data_addr[IDX_W+1:2];
    assign in_range  = m_data_addr < BYTE_LIMIT;
    assign wr_req    = |m_data_byteen;
    assign wr_commit = wr_req && in_range;

    // Reads see the word as it stood before this cycle's write lands.
    assign rd_word      = in_range ? mem_q[idx] : 32'h0;
    assign m_data_rdata = rd_word;

    always_comb begin
        merged_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged_word[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (m_data_byteen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: byteen_legal = 1'b1;
            default:                            byteen_legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_count_d   = wr_count_q;
        err_oor_d    = err_oor_q;
        err_byteen_d = err_byteen_q | ~byteen_legal;
        err_addr_d   = err_addr_q;
        if (wr_commit && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (wr_req && !in_range) begin
            err_oor_d = 1'b1;
            if (!err_oor_q) begin
                err_addr_d = m_data_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem_q[w] <= 32'h0;
            end
            wr_count_q   <= 16'h0;
            err_oor_q    <= 1'b0;
            err_byteen_q <= 1'b0;
            err_addr_q   <= 32'h0;
        end else begin
            if (wr_commit) begin
                mem_q[idx] <= merged_word;
            end
            wr_count_q   <= wr_count_d;
            err_oor_q    <= err_oor_d;
            err_byteen_q <= err_byteen_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign wr_count   = wr_count_q;
    assign err_oor    = err_oor_q;
    assign err_byteen = err_byteen_q;
    assign err_addr   = err_addr_q;

`ifdef DM_TRACE_EN
    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q,    trace_pc_d;
    logic [31:0] trace_addr_q,  trace_addr_d;
    logic [31:0] trace_data_q,  trace_data_d;

    always_comb begin
        trace_valid_d = wr_commit;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        if (wr_commit) begin
            trace_pc_d   = m_inst_addr;
            trace_addr_d = {m_data_addr[31:2], 2'b00};
            trace_data_d = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0;
            trace_addr_q  <= 32'h0;
            trace_data_q  <= 32'h0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (trace_valid_q) begin
            $display("@%h: *%h <= %h", trace_pc_q, trace_addr_q, trace_data_q);
        end
    end
`endif
`else
    logic unused_trace;
    assign unused_trace = ^{m_inst_addr, merged_word};
    assign trace_valid  = 1'b0;
    assign trace_pc     = 32'h0;
    assign trace_addr   = 32'h0;
    assign trace_data   = 32'h0;
`endif

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder at the far end of the pipeline's M-stage memory port.
- Samples `m_data_addr`, `m_data_wdata`, `m_data_byteen` and `m_inst_addr` from the datapath.
- Performs byte-lane-masked writes and returns `m_data_rdata` combinationally, so the pipeline sees read data in the same cycle.
- Also produces a registered write-trace stream and sticky error flags, used for comparison against the reference simulator log.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (12 KiB, byte range 0x0000–0x2FFF).
- IDX_W, 12, word-index width; must satisfy 2^IDX_W >= DEPTH_WORDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- m_data_addr  input  32  byte address from the M stage.
- m_data_wdata  input  32  write data, already lane-aligned by the byte-enable unit.
- m_data_byteen  input  4  per-byte write enable; bit i controls byte lane [8i+7:8i].
- m_inst_addr  input  32  PC of the instruction currently in the M stage.
- m_data_rdata  output  32  word read at `m_data_addr`.
- trace_valid  output  1  one-cycle pulse: a write completed on the previous edge.
- trace_pc  output  32  PC of the traced write.
- trace_addr  output  32  word-aligned address of the traced write.
- trace_data  output  32  full merged word after the write.
- wr_count  output  16  number of committed writes, saturating.
- err_oor  output  1  sticky: a write was attempted out of range.
- err_byteen  output  1  sticky: a non-standard byte-enable pattern was seen.
- err_addr  output  32  address of the first out-of-range write.

Behaviour:
- Address decode
  - `idx = m_data_addr[IDX_W+1:2]`.
  - A request is in range iff `m_data_addr < 4*DEPTH_WORDS`.
  - `m_data_addr[1:0]` is ignored for indexing.
- Read
  - Purely combinational: `m_data_rdata = mem[idx]` when in range, else 32'h0.
  - No read enable.
  - A read in the same cycle as a write to the same word returns the pre-write value.
- Write, on rising edge when `reset=0`, `|m_data_byteen`, and in range
  - For each i with `byteen[i]=1`: `mem[idx][8i+7:8i] <= wdata[8i+7:8i]`.
  - Other lanes are unchanged.
  - `wr_count` increments and saturates at 16'hFFFF.
- Write out of range (`|byteen`, not in range)
  - Memory is not modified and `wr_count` does not change.
  - `err_oor <= 1`.
  - `err_addr` captures `m_data_addr` only if `err_oor` was 0 before this edge.
- Byte-enable legality
  - Legal patterns: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other nonzero pattern sets `err_byteen`, but the write is still performed lane-by-lane.
- Trace (one-cycle latency)
  - On the edge after a committed in-range write: `trace_valid=1`, `trace_pc=m_inst_addr`, `trace_addr={m_data_addr[31:2],2'b00}`, `trace_data` = merged word.
  - Otherwise `trace_valid=0`; the other trace fields hold their last values.
  - Out-of-range writes produce no trace.
- Back-to-back writes: one trace pulse per cycle, no loss, no merging.
- Reset (synchronous, including mid-stream)
  - All `mem` words become 0.
  - `trace_valid=0`, `trace_pc=0`, `trace_addr=0`, `trace_data=0`.
  - `wr_count=0`, `err_oor=0`, `err_byteen=0`, `err_addr=0`.
  - A write presented in the same cycle as reset is discarded.
  - `m_data_rdata` reflects the zeroed memory from the cycle after reset onward.
- No handshake: the responder is always ready, and any request completes in the cycle it is presented.

Optional Feature:
- Macro: `DM_TRACE_EN`.
- Defined:
  - trace outputs behave as above;
  - a `$display("@%h: *%h <= %h", trace_pc, trace_addr, trace_data)` is issued on each `trace_valid` edge.
- Undefined:
  - `trace_valid`, `trace_pc`, `trace_addr`, `trace_data` are tied to 0;
  - the trace registers and `$display` are not generated;
  - memory, read path, counter and error flags are unchanged.

Test Plan:
- **Word write.** Reset, then `addr=0x0000_0010`, `wdata=0x1234_5678`, `byteen=1111`, `pc=0x0000_3000`.
  - Next cycle: `trace_valid=1`, `trace_addr=0x10`, `trace_data=0x1234_5678`, `trace_pc=0x3000`, `wr_count=1`.
  - `rdata@0x10 = 0x1234_5678`.
- **Byte merge.** After the word write, write `addr=0x11`, `wdata=0x0000_AB00`, `byteen=0010`.
  - `rdata@0x10 = 0x1234_AB78`; `trace_data=0x1234_AB78`; `err_byteen=0`.
- **Read-during-write.** Same cycle: `rdata` shows the old word. Following cycle: `rdata` shows the new word.
- **Out of range.** `addr=0x0000_3000`, `byteen=1111`.
  - No trace; `err_oor=1`; `err_addr=0x3000`; `wr_count` unchanged.
  - A second out-of-range write at `0x4000`: `err_addr` stays `0x3000`.
- **Illegal pattern.** `byteen=0101`, `addr=0x20`, `wdata=0xAABB_CCDD`.
  - `rdata@0x20 = 0x00BB_00DD`; `err_byteen=1`; trace emitted.
- **Mid-stream reset.**
  - Stimulus: three back-to-back writes; assert reset together with the third.
  - Trace pulses for the first two writes, then all outputs 0 and `rdata=0` at every written address.
  - The third write is not observed.
